ysyx_25040105_lsu: RTL and testbench

- Load/store stage directly downstream of the execute stage.
- Consumes the execute result (effective address, or a plain ALU result) together with rs2 store data.
- Issues one memory transaction over a valid/ready request plus response-valid bus, then hands the aligned and extended result to writeback.
- Multi-cycle and single-outstanding; it is controlled by a 4-state FSM.

---
 rtl/ysyx_25040105_lsu.sv | 193 +++++++++++++++++++
 tb/tb_ysyx_25040105_lsu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040105_lsu.sv
// Load/store unit sitting after execute. Accepts one instruction at a time.
// Loads and stores go out on a valid/ready request bus and wait for a
// response. Everything else passes the execute result straight through.
// The aligned and extended result is then presented to writeback.
module ysyx_25040105_lsu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  // upstream (execute)
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_is_load,
  input  logic            in_is_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [RD_W-1:0] in_rd,
  // memory bus
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  // downstream (writeback)
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_off;      // byte offset of the access within the word
  logic [2:0]      r_funct3;
  logic            r_is_load;

  logic            w_accept;
  logic            w_mem_op;
  logic            w_f3_ok;
  logic            w_align_ok;
  logic            w_fault;
  logic [1:0]      w_off;
  logic [3:0]      w_wmask;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ldata;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_off    = in_addr[1:0];
  assign w_mem_op = in_is_load || in_is_store;

  // Decide whether an incoming load/store is legal (size encoding and alignment).
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_f3_ok    = 1'b0;
    w_align_ok = 1'b1;
    if (in_is_load && !in_is_store) begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
        default:                                w_f3_ok = 1'b0;
      endcase
    end else if (in_is_store && !in_is_load) begin
      case (in_funct3)
        3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
        default:                w_f3_ok = 1'b0;
      endcase
    end
    case (in_funct3[1:0])
      2'b01:   w_align_ok = !w_off[0];
      2'b10:   w_align_ok = (w_off == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    w_fault = w_mem_op && !(w_f3_ok && w_align_ok);
  end

  // Place store data on the byte lanes selected by size and offset.
  always_comb begin
    w_wmask = 4'b0000;
    w_wdata = '0;
    if (in_is_store) begin
      case (in_funct3[1:0])
        2'b00: begin
          w_wmask = 4'b0001 << w_off;
          w_wdata = {(XLEN/8){in_wdata[7:0]}};
        end
        2'b01: begin
          w_wmask = w_off[1] ? 4'b1100 : 4'b0011;
          w_wdata = {(XLEN/16){in_wdata[15:0]}};
        end
        default: begin
          w_wmask = 4'b1111;
          w_wdata = in_wdata;
        end
      endcase
    end
  end

  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];

  // Pick the loaded byte/half/word and sign- or zero-extend it.
  always_comb begin
    w_ldata = mem_rdata;
    case (r_funct3)
      3'b000:  w_ldata = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_ldata = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_ldata = {{(XLEN-16){1'b0}}, w_half};
      default: w_ldata = mem_rdata;
    endcase
  end

  // Transaction FSM. All bus and writeback outputs are registered here.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_off         <= 2'b00;
      r_funct3      <= 3'b000;
      r_is_load     <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= 4'b0000;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_rd        <= '0;
      out_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off     <= w_off;
            r_funct3  <= in_funct3;
            r_is_load <= in_is_load;
            out_rd    <= in_rd;
            if (!w_mem_op || w_fault) begin
              // pass-through or faulting access: no bus traffic
              out_result <= in_addr;
              out_err    <= w_fault;
              out_valid  <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_addr      <= {in_addr[XLEN-1:2], 2'b00};
              mem_wen       <= in_is_store;
              mem_wmask     <= w_wmask;
              mem_wdata     <= w_wdata;
              out_err       <= 1'b0;
              r_state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            out_result <= r_is_load ? w_ldata : '0;
            out_valid  <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040105_lsu.sv
// Self-checking bench for the LSU. The driver pushes the expected writeback
// record when it issues an instruction. A negedge monitor pops and compares
// on every writeback handshake. Inputs change 1ns after posedge; all sampling
// happens on negedge.
`timescale 1ns/1ps
module tb_ysyx_25040105_lsu;

  localparam int XLEN = 32;
  localparam int RD_W = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_is_load = 1'b0;
  logic            in_is_store = 1'b0;
  logic [2:0]      in_funct3 = 3'b000;
  logic [XLEN-1:0] in_addr = '0;
  logic [XLEN-1:0] in_wdata = '0;
  logic [RD_W-1:0] in_rd = '0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [XLEN-1:0] mem_addr;
  logic            mem_wen;
  logic [XLEN-1:0] mem_wdata;
  logic [3:0]      mem_wmask;
  logic            mem_rsp_valid = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_err;

  ysyx_25040105_lsu #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Writeback monitor: one scoreboard entry per handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_pending", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wb_result", out_result, mon_e.result);
        check("wb_rd", {27'b0, out_rd}, {27'b0, mon_e.rd});
        check("wb_err", {31'b0, out_err}, {31'b0, mon_e.err});
      end
    end
  end

  // One complete instruction: issue, optional bus transaction with the given
  // stalls, then writeback with the given backpressure. Entered and left at posedge+1.
  task automatic run_op(
    input string       name,
    input logic        ld,
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [4:0]  rd,
    input logic [31:0] rdata,
    input int          req_dly,
    input int          rsp_dly,
    input int          out_dly,
    input logic        exp_mem,
    input logic [3:0]  exp_mask,
    input logic [31:0] exp_wdata,
    input logic [31:0] exp_result,
    input logic        exp_err
  );
    exp_t        e;
    int          guard;
    logic [31:0] exp_maddr;
    exp_maddr   = {addr[31:2], 2'b00};
    in_valid    = 1'b1;
    in_is_load  = ld;
    in_is_store = st;
    in_funct3   = f3;
    in_addr     = addr;
    in_wdata    = wdata;
    in_rd       = rd;
    e.result    = exp_result;
    e.rd        = rd;
    e.err       = exp_err;
    sb.push_back(e);
    guard = 0;
    at_neg();
    while (!in_ready && guard < 20) begin
      tick();
      at_neg();
      guard++;
    end
    check({name, ":in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_valid    = 1'b0;
    in_is_load  = 1'b0;
    in_is_store = 1'b0;
    in_wdata    = 32'h5A5A_5A5A;  // prove request data was captured at accept
    if (exp_mem) begin
      for (int i = 0; i <= req_dly; i++) begin
        if (i == req_dly) mem_req_ready = 1'b1;
        at_neg();
        check({name, ":req_valid"}, {31'b0, mem_req_valid}, 32'd1);
        check({name, ":mem_addr"}, mem_addr, exp_maddr);
        check({name, ":mem_wen"}, {31'b0, mem_wen}, {31'b0, st});
        check({name, ":mem_wmask"}, {28'b0, mem_wmask}, {28'b0, exp_mask});
        if (st) check({name, ":mem_wdata"}, mem_wdata, exp_wdata);
        check({name, ":in_ready_busy"}, {31'b0, in_ready}, 32'd0);
        tick();
      end
      mem_req_ready = 1'b0;
      for (int k = 0; k < rsp_dly; k++) begin
        at_neg();
        check({name, ":wait_req_low"}, {31'b0, mem_req_valid}, 32'd0);
        check({name, ":wait_out_low"}, {31'b0, out_valid}, 32'd0);
        tick();
      end
      mem_rsp_valid = 1'b1;
      mem_rdata     = rdata;
      at_neg();
      check({name, ":wait_req_low"}, {31'b0, mem_req_valid}, 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'hA5A5_A5A5;  // result must already be registered
    end
    for (int j = 0; j <= out_dly; j++) begin
      if (j == out_dly) out_ready = 1'b1;
      at_neg();
      check({name, ":out_valid"}, {31'b0, out_valid}, 32'd1);
      check({name, ":out_hold"}, out_result, exp_result);
      check({name, ":in_ready_done"}, {31'b0, in_ready}, 32'd0);
      check({name, ":no_req"}, {31'b0, mem_req_valid}, 32'd0);
      tick();
    end
    out_ready = 1'b0;
    at_neg();
    check({name, ":out_drop"}, {31'b0, out_valid}, 32'd0);
    check({name, ":back_idle"}, {31'b0, in_ready}, 32'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    tick();
    at_neg();
    check("rst:in_ready", {31'b0, in_ready}, 32'd1);
    check("rst:req_valid", {31'b0, mem_req_valid}, 32'd0);
    check("rst:mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst:mem_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:mem_wdata", mem_wdata, 32'd0);
    check("rst:out_valid", {31'b0, out_valid}, 32'd0);
    check("rst:out_result", out_result, 32'd0);
    check("rst:out_rd", {27'b0, out_rd}, 32'd0);
    check("rst:out_err", {31'b0, out_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    //      name     ld    st    f3      addr           wdata          rd     rdata          rq rs ob mem   mask     wdata          result         err
    run_op("pass",  1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0,        5'd5,  32'h0,         0, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h1234_5678, 1'b0);
    run_op("lb",    1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,        5'd7,  32'h80FF_0011, 0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80, 1'b0);
    run_op("lbu",   1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,        5'd8,  32'h80FF_0011, 0, 1, 0, 1'b1, 4'b0000, 32'h0,         32'h0000_0080, 1'b0);
    run_op("sh_hi", 1'b0, 1'b1, 3'b001, 32'h8000_0102, 32'hDEAD_BEEF, 5'd0, 32'h0,         0, 0, 0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         1'b0);
    run_op("bp_lh", 1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,        5'd9,  32'h80FF_0011, 3, 2, 2, 1'b1, 4'b0000, 32'h0,         32'hFFFF_80FF, 1'b0);
    run_op("lw_mis",1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,        5'd10, 32'h0,         0, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h8000_0002, 1'b1);
    run_op("sh_mis",1'b0, 1'b1, 3'b001, 32'h8000_0001, 32'h1111_2222, 5'd11, 32'h0,        0, 0, 1, 1'b0, 4'b0000, 32'h0,         32'h8000_0001, 1'b1);
    run_op("st_f3", 1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h0,        5'd12, 32'h0,         0, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h8000_0000, 1'b1);
    run_op("ld_f3", 1'b1, 1'b0, 3'b011, 32'h8000_0000, 32'h0,        5'd13, 32'h0,         0, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h8000_0000, 1'b1);
    run_op("ld_st", 1'b1, 1'b1, 3'b010, 32'h8000_0008, 32'h0,        5'd14, 32'h0,         0, 0, 0, 1'b0, 4'b0000, 32'h0,         32'h8000_0008, 1'b1);
    run_op("sb_1",  1'b0, 1'b1, 3'b000, 32'h8000_0011, 32'h1234_56A5, 5'd15, 32'h0,        1, 0, 1, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0,         1'b0);
    run_op("sh_lo", 1'b0, 1'b1, 3'b001, 32'h8000_0040, 32'h0BAD_C0DE, 5'd16, 32'h0,        0, 0, 0, 1'b1, 4'b0011, 32'hC0DE_C0DE, 32'h0,         1'b0);
    run_op("sw",    1'b0, 1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D, 5'd17, 32'h0,        0, 1, 0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0);
    run_op("lhu",   1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0,        5'd18, 32'h1234_8765, 0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h0000_8765, 1'b0);
    run_op("lh_lo", 1'b1, 1'b0, 3'b001, 32'h8000_0000, 32'h0,        5'd19, 32'h1234_8765, 0, 0, 0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_8765, 1'b0);
    run_op("lb_1",  1'b1, 1'b0, 3'b000, 32'h8000_0001, 32'h0,        5'd20, 32'h0000_7F00, 2, 0, 0, 1'b1, 4'b0000, 32'h0,         32'h0000_007F, 1'b0);
    run_op("pass2", 1'b0, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'h0,        5'd31, 32'h0,         0, 0, 1, 1'b0, 4'b0000, 32'h0,         32'hFFFF_FFFF, 1'b0);

    // reset while waiting for a load response, then a stray response
    in_valid    = 1'b1;
    in_is_load  = 1'b1;
    in_funct3   = 3'b010;
    in_addr     = 32'h8000_0000;
    in_rd       = 5'd3;
    tick();
    in_valid      = 1'b0;
    in_is_load    = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    at_neg();
    check("rstw:in_wait_busy", {31'b0, in_ready}, 32'd0);
    check("rstw:in_wait_req", {31'b0, mem_req_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check("rstw:async_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h7777_7777;
    tick();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("rstw:out_low", {31'b0, out_valid}, 32'd0);
      check("rstw:idle", {31'b0, in_ready}, 32'd1);
      tick();
    end
    run_op("lw_post", 1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 5'd4, 32'h0000_0042, 0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0000_0042, 1'b0);

    at_neg();
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
